bcd_to_binary: RTL and testbench

Sequential BCD-to-binary converter, the inverse of the display-side binary-to-BCD path. It converts operands entered digit-by-digit on the keypad, held as packed BCD plus a sign flag, into two's-complement binary for the ALU. It uses a multiply-accumulate loop, most significant digit first, at one digit per clock. A start/busy/done handshake sits between the input controller and the operand registers.

---
 rtl/calc_pkg.sv | 17 +
 rtl/bcd_to_binary_if.sv | 27 ++
 rtl/bcd_to_binary_mac.sv | 24 ++
 rtl/bcd_to_binary.sv | 130 +++++++++++++
 tb/tb_bcd_to_binary.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter state encoding, BCD constants and
// the packed-BCD width helper shared with the display path.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd2bin_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Start/busy/done handshake and result bus between the input controller
// (master) and the BCD-to-binary converter (slave).
interface bcd_to_binary_if #(
  parameter int N      = 32,
  parameter int DIGITS = 10
) ();

  logic                                  start;
  logic [calc_pkg::bcd_width(DIGITS)-1:0] bcd_in;
  logic                                  neg_in;
  logic                                  busy;
  logic                                  done;
  logic [N-1:0]                          bin_out;
  logic                                  overflow;
  logic                                  invalid;

  modport master (
    output start, bcd_in, neg_in,
    input  busy, done, bin_out, overflow, invalid
  );

  modport slave (
    input  start, bcd_in, neg_in,
    output busy, done, bin_out, overflow, invalid
  );

endinterface

// File: rtl/bcd_to_binary_mac.sv
// One multiply-accumulate step: t = acc*10 + d, with the signed-magnitude
// limit compare and a non-decimal digit flag.
module bcd_digit_mac
  import calc_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N+3:0] acc,
  input  logic [3:0]   d,
  input  logic         neg,
  output logic [N+3:0] t,
  output logic         exceeds,
  output logic         bad_digit
);

  logic [N+3:0] limit;

  // Four guard bits above N keep acc*10+9 from wrapping for any acc <= 2^(N-1).
  assign t         = (acc << 3) + (acc << 1) + (N+4)'(d);
  assign limit     = {5'b0, {(N-1){1'b1}}} + (N+4)'(neg);
  assign exceeds   = t > limit;
  assign bad_digit = d > BCD_DIGIT_MAX;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to two's-complement converter, one digit per clock,
// most significant digit first.
module bcd_to_binary
  import calc_pkg::*;
#(
  parameter int N      = 32,
  parameter int DIGITS = 10
) (
  input  logic            clk,
  input  logic            reset,
  bcd_to_binary_if.slave  bus
);

  localparam int W    = bcd_width(DIGITS);
  localparam int AW   = N + 4;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd2bin_state_t  state_q, state_d;
  logic [W-1:0]    sr_q;
  logic            neg_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [IDXW-1:0] idx_q;
  logic            ovf_q, ovf_d;
  logic            inv_q, inv_d;
  logic [N-1:0]    bin_q;
  logic            overflow_q;
  logic            invalid_q;

  logic [AW-1:0]   mac_t;
  logic            mac_exceeds;
  logic            mac_bad;
  logic            last_digit;

  bcd_digit_mac #(.N(N)) u_mac (
    .acc       (acc_q),
    .d         (sr_q[W-1 -: 4]),
    .neg       (neg_q),
    .t         (mac_t),
    .exceeds   (mac_exceeds),
    .bad_digit (mac_bad)
  );

  assign last_digit = (idx_q == '0);

  // Overflow is sticky and freezes acc, but later digits are still checked.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_d = acc_q;
    ovf_d = ovf_q;
    inv_d = inv_q;
    if (mac_bad) begin
      inv_d = 1'b1;
    end else if (!ovf_q) begin
      if (mac_exceeds) ovf_d = 1'b1;
      else             acc_d = mac_t;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CONV;
      CONV:    if (last_digit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      inv_q      <= 1'b0;
      bin_q      <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          sr_q  <= bus.bcd_in;
          neg_q <= bus.neg_in;
          acc_q <= '0;
          idx_q <= IDXW'(DIGITS - 1);
          ovf_q <= 1'b0;
          inv_q <= 1'b0;
        end
        CONV: begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          inv_q <= inv_d;
          sr_q  <= sr_q << 4;
          idx_q <= idx_q - 1'b1;
          // Results are built from the final digit's update so they land with done.
          if (last_digit) begin
            if (inv_d) begin
              bin_q      <= '0;
              overflow_q <= 1'b0;
              invalid_q  <= 1'b1;
            end else if (ovf_d) begin
              bin_q      <= '0;
              overflow_q <= 1'b1;
              invalid_q  <= 1'b0;
            end else begin
              bin_q      <= neg_q ? (N'(0) - acc_d[N-1:0]) : acc_d[N-1:0];
              overflow_q <= 1'b0;
              invalid_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.bin_out  = bin_q;
  assign bus.overflow = overflow_q;
  assign bus.invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_bcd_to_binary;
  import calc_pkg::*;

  localparam int N      = 32;
  localparam int DIGITS = 10;

  typedef struct {
    logic [N-1:0] bin;
    logic         ovf;
    logic         inv;
    int           cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   failed;
  exp_t sb[$];

  bcd_to_binary_if #(.N(N), .DIGITS(DIGITS)) bus ();

  bcd_to_binary #(.N(N), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", bus.done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bin_out",  bus.bin_out,  e.bin);
        check("overflow", bus.overflow, e.ovf);
        check("invalid",  bus.invalid,  e.inv);
        check("latency",  cyc - e.cyc,  DIGITS + 1);
      end
    end
  end

  // Called #1 after a posedge; leaves at #1 after the next posedge.
  task automatic pulse_start(input logic [39:0] bcd, input logic neg);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    bus.neg_in = neg;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.bcd_in = 40'hFFFF_FFFF_FF;
    bus.neg_in = ~neg;
  endtask

  task automatic issue(input logic [39:0] bcd, input logic neg,
                       input logic [N-1:0] bin, input logic ovf, input logic inv);
    exp_t e;
    e.bin = bin;
    e.ovf = ovf;
    e.inv = inv;
    e.cyc = cyc;
    sb.push_back(e);
    pulse_start(bcd, neg);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 64 && bus.busy; k++) begin
      @(posedge clk); #1;
    end
    if (bus.busy) check("busy_timeout", bus.busy, 1'b0);
  endtask

  task automatic convert(input logic [39:0] bcd, input logic neg,
                         input logic [N-1:0] bin, input logic ovf, input logic inv);
    issue(bcd, neg, bin, ovf, inv);
    wait_idle();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    bus.neg_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    @(negedge clk);
    check("rst_busy",     bus.busy,     1'b0);
    check("rst_done",     bus.done,     1'b0);
    check("rst_bin_out",  bus.bin_out,  '0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_invalid",  bus.invalid,  1'b0);
    @(posedge clk); #1;

    // Basic conversion with busy window: high in cycles 1..11 only.
    issue(40'h00_0000_0042, 1'b0, 32'h0000_002A, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("busy_c%0d", k), bus.busy, (k <= 11) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk); #1;
    check("hold_bin_out", bus.bin_out, 32'h0000_002A);

    // Signed range boundaries.
    convert(40'h21_4748_3647, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0);
    convert(40'h21_4748_3648, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    convert(40'h21_4748_3648, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
    convert(40'h99_9999_9999, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    convert(40'h00_0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
    convert(40'h00_0000_0123, 1'b1, 32'hFFFF_FF85, 1'b0, 1'b0);

    // Non-decimal nibbles.
    convert(40'h00_000A_0012, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    convert(40'h99_9999_99F9, 1'b0, 32'h0000_0000, 1'b0, 1'b1);

    // Starts while busy are ignored; start right after DONE is accepted.
    issue(40'h00_0001_2345, 1'b0, 32'h0000_3039, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;
    pulse_start(40'h00_0000_0999, 1'b1);
    repeat (7) @(posedge clk); #1;
    pulse_start(40'h00_0000_0555, 1'b0);
    issue(40'h00_0000_0100, 1'b0, 32'h0000_0064, 1'b0, 1'b0);
    wait_idle();

    // Reset at cycle 5 of a conversion aborts it with no done.
    pulse_start(40'h00_0000_0321, 1'b0);
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy",     bus.busy,     1'b0);
    check("abort_done",     bus.done,     1'b0);
    check("abort_bin_out",  bus.bin_out,  '0);
    check("abort_overflow", bus.overflow, 1'b0);
    check("abort_invalid",  bus.invalid,  1'b0);
    repeat (15) @(posedge clk); #1;
    convert(40'h00_0000_0777, 1'b0, 32'h0000_0309, 1'b0, 1'b0);

    repeat (4) @(posedge clk); #1;
    check("scoreboard_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
